// File: rtl/psqwm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// psqwm : programmable square-wave meter
//
// Measures the high and low durations of an external square wave in 100 ns
// units and reports them once per complete period (high phase followed by
// low phase, closed by the next rising edge).
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-low
//   en     in   measurement enable; dropping it returns the meter to IDLE
//   sq_in  in   asynchronous square-wave input
//   m_out  out  high duration of the last complete period, in units
//   n_out  out  low duration of the last complete period, in units
//   valid  out  one-cycle strobe, m_out/n_out/err update in the same cycle
//   err    out  last period was non-integral, zero-length or overflowed
//   busy   out  meter is in the HIGH or LOW state
// ---------------------------------------------------------------------------
module psqwm #(
    parameter int T      = 20,
    parameter int M_BITS = 4,
    parameter int N_BITS = 4,
    parameter int U_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sq_in,
    output logic [M_BITS-1:0] m_out,
    output logic [N_BITS-1:0] n_out,
    output logic              valid,
    output logic              err,
    output logic              busy
);

    localparam int TICKS  = 100 / T;
    localparam int P_BITS = $clog2(TICKS);

    localparam logic [P_BITS-1:0] P_LAST  = P_BITS'(TICKS - 1);
    localparam logic [P_BITS-1:0] P_ONE   = P_BITS'(1);
    localparam logic [U_BITS-1:0] U_MAX   = {U_BITS{1'b1}};
    localparam logic [U_BITS-1:0] M_LIMIT = U_BITS'((1 << M_BITS) - 1);
    localparam logic [U_BITS-1:0] N_LIMIT = U_BITS'((1 << N_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } state_t;

    state_t            state;
    logic              s1, s2, s3;
    logic              rise, fall;
    logic [P_BITS-1:0] presc;
    logic [U_BITS-1:0] unit;
    logic [U_BITS-1:0] m_meas;
    logic              m_bad;

    // A phase is bad when it does not end on a unit boundary, is shorter
    // than one unit, or does not fit in the output field.
    function automatic logic phase_bad(input logic [U_BITS-1:0] u,
                                       input logic [P_BITS-1:0] p,
                                       input logic [U_BITS-1:0] limit);
        return (p != '0) || (u == '0) || (u > limit);
    endfunction

    // Two-flop synchronizer (s1, s2) plus a history flop (s3) for edge
    // detection on the synchronized input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Duration counter: the prescaler divides the clock down to 100 ns
    // units and the unit counter counts whole units, saturating. The edge
    // cycle itself is the first cycle of the new phase, so the prescaler
    // restarts at 1 rather than 0. At the closing edge the unit counter is
    // floor(D/TICKS) and a non-zero prescaler is the remainder.
    always_ff @(posedge clk) begin
        if (!rst || state == IDLE) begin
            presc <= '0;
            unit  <= '0;
        end else if (rise || fall) begin
            presc <= P_ONE;
            unit  <= '0;
        end else if (presc == P_LAST) begin
            presc <= '0;
            if (unit != U_MAX) begin
                unit <= unit + U_BITS'(1);
            end
        end else begin
            presc <= presc + P_ONE;
        end
    end

    // Measurement FSM with registered outputs. ARM waits for a rising edge
    // so that a partial period seen at enable time is never reported. The
    // high phase is latched on the fall; the report is produced on the rise
    // that closes the low phase, which is also the start of the next period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            m_out  <= '0;
            n_out  <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            m_meas <= '0;
            m_bad  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        busy  <= 1'b0;
                    end
                    ARM: begin
                        if (rise) begin
                            state <= HIGH;
                            busy  <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            m_meas <= unit;
                            m_bad  <= phase_bad(unit, presc, M_LIMIT);
                            state  <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            m_out <= (m_meas > M_LIMIT) ? {M_BITS{1'b1}}
                                                        : m_meas[M_BITS-1:0];
                            n_out <= (unit > N_LIMIT) ? {N_BITS{1'b1}}
                                                      : unit[N_BITS-1:0];
                            err   <= m_bad | phase_bad(unit, presc, N_LIMIT);
                            valid <= 1'b1;
                            state <= HIGH;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psqwm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_psqwm : self-checking bench for the square-wave meter.
//
// The stimulus process drives directed square-wave periods and pushes the
// hand-computed result of each reported period into a scoreboard queue.
// A monitor pops and compares whenever valid is seen. Directed checks cover
// reset values, busy, the enable drop and a mid-measurement reset.
// Clock period is 20 ns, so one unit is 5 clocks.
// ---------------------------------------------------------------------------
module tb_psqwm;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sq_in;
    logic [3:0] m_out;
    logic [3:0] n_out;
    logic       valid;
    logic       err;
    logic       busy;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] n;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   assertions = 0;
    int   failures   = 0;

    psqwm #(
        .T(20),
        .M_BITS(4),
        .N_BITS(4),
        .U_BITS(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sq_in(sq_in),
        .m_out(m_out),
        .n_out(n_out),
        .valid(valid),
        .err(err),
        .busy(busy)
    );

    // 20 ns clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Hold sq_in at a level for a number of clocks; entered and left just
    // after a rising edge
    task automatic driveLevel(input logic lvl, input int cycles);
        sq_in = lvl;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // One period: high for h clocks, low for l clocks. When push is set the
    // hand-computed result is queued; it is reported on the next rise.
    task automatic applyStimulus(input int h, input int l, input bit push,
                                 input int m, input int n, input bit e);
        exp_t x;
        if (push) begin
            x.m = 4'(m);
            x.n = 4'(n);
            x.e = e;
            sb.push_back(x);
        end
        driveLevel(1'b1, h);
        driveLevel(1'b0, l);
    endtask

    // Scoreboard monitor: compares every valid strobe against the queue
    always @(negedge clk) begin
        if (rst === 1'b1 && valid === 1'b1) begin
            checkOutput("sb_nonempty_on_valid", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                checkOutput("m_out", int'(m_out), int'(x.m));
                checkOutput("n_out", int'(n_out), int'(x.n));
                checkOutput("err", int'(err), int'(x.e));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        en    = 1'b0;
        sq_in = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_m_out", int'(m_out), 0);
        checkOutput("reset_n_out", int'(n_out), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b1;

        // Armed but no edge yet: not busy
        driveLevel(1'b0, 6);
        @(negedge clk);
        checkOutput("busy_in_arm", int'(busy), 0);
        @(posedge clk);
        #1;

        // Nominal periods, then boundary and error cases
        for (int i = 0; i < 4; i++) applyStimulus(15, 10, 1'b1, 3, 2, 1'b0);
        applyStimulus(75, 5, 1'b1, 15, 1, 1'b0);
        applyStimulus(100, 10, 1'b1, 15, 2, 1'b1);
        applyStimulus(17, 10, 1'b1, 3, 2, 1'b1);
        applyStimulus(3, 10, 1'b1, 0, 2, 1'b1);
        applyStimulus(15, 10, 1'b1, 3, 2, 1'b0);

        // Close the last period, then drop enable during the next low phase
        driveLevel(1'b1, 15);
        driveLevel(1'b0, 6);
        @(negedge clk);
        checkOutput("busy_in_low", int'(busy), 1);
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_after_en_drop", int'(busy), 0);
        checkOutput("hold_m_out", int'(m_out), 3);
        checkOutput("hold_n_out", int'(n_out), 2);
        checkOutput("hold_err", int'(err), 0);
        @(posedge clk);
        #1;

        // Rise while disabled produces nothing; re-enable mid-high, the
        // partial period is discarded and one full period is reported
        driveLevel(1'b0, 3);
        driveLevel(1'b1, 5);
        en = 1'b1;
        driveLevel(1'b1, 10);
        driveLevel(1'b0, 10);
        applyStimulus(15, 10, 1'b1, 3, 2, 1'b0);
        driveLevel(1'b1, 12);
        checkOutput("sb_drained_after_reenable", sb.size(), 0);

        // Reset sampled on the same edge that would process the fall
        sq_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_m_out", int'(m_out), 0);
        checkOutput("midrst_n_out", int'(n_out), 0);
        checkOutput("midrst_err", int'(err), 0);
        checkOutput("midrst_valid", int'(valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Re-arm and resume normal measurement
        driveLevel(1'b0, 8);
        applyStimulus(15, 10, 1'b1, 3, 2, 1'b0);
        applyStimulus(15, 10, 1'b1, 3, 2, 1'b0);
        driveLevel(1'b1, 12);
        driveLevel(1'b0, 4);

        checkOutput("sb_drained_at_end", sb.size(), 0);
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
